// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and byte-lane sizing.
package imem_loader_pkg;

    localparam int unsigned LaneW     = 2;
    localparam int unsigned WordBytes = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHdr     = 3'd1,
        StPayload = 3'd2,
        StCsum    = 3'd3,
        StDone    = 3'd4,
        StErr     = 3'd5
    } state_t;

endpackage

// File: rtl/byte_to_word.sv
// Little-endian byte-to-word assembler: collects four accepted bytes and flags the completed word.
module byte_to_word
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [LaneW-1:0] lane_q;
    logic [23:0]      shreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else if (clear) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else if (accept) begin
            lane_q <= lane_q + LaneW'(1);
            for (int k = 0; k < 3; k++) begin
                if (lane_q == LaneW'(k)) begin
                    shreg_q[8*k +: 8] <= in_byte;
                end
            end
        end
    end

    // The top byte is taken straight from the bus so the word is usable on its accepting edge.
    assign word_valid = accept && (lane_q == LaneW'(WordBytes - 1));
    assign word       = {in_byte, shreg_q};

endmodule

// File: rtl/imem_loader.sv
// Framed-image loader: header count, payload words written to instruction memory, XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 8192,
    parameter int unsigned CNT_W       = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            wr_en,
    output logic [XLEN-1:0] wr_addr,
    output logic [31:0]     wr_data,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            core_rst
);

    state_t            state;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  n_words;
    logic [31:0]       csum;
    logic [31:0]       word;
    logic              word_valid;
    logic              accept;
    logic              arm;

    assign accept = in_valid && in_ready;
    assign arm    = start && (state == StIdle || state == StDone || state == StErr);

    byte_to_word u_b2w (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (in_data),
        .accept     (accept),
        .clear      (arm),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            core_rst <= 1'b1;
            word_idx <= '0;
            n_words  <= '0;
            csum     <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                StIdle, StDone, StErr: begin
                    if (arm) begin
                        state    <= StHdr;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        core_rst <= 1'b1;
                        word_idx <= '0;
                        n_words  <= '0;
                        csum     <= '0;
                    end
                end
                StHdr: begin
                    if (word_valid) begin
                        if (word > DEPTH_WORDS) begin
                            state    <= StErr;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else if (word == '0) begin
                            state <= StCsum;
                        end else begin
                            state   <= StPayload;
                            n_words <= CNT_W'(word);
                        end
                    end
                end
                StPayload: begin
                    if (word_valid) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= XLEN'({word_idx, {LaneW{1'b0}}});
                        wr_data  <= word;
                        csum     <= csum ^ word;
                        word_idx <= word_idx + CNT_W'(1);
                        if (word_idx == n_words - CNT_W'(1)) begin
                            state <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (word_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (word == csum) begin
                            state    <= StDone;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side counterpart of the instruction memory: it fills instruction memory from a byte stream, for example a UART RX or debug bridge. It accepts a framed image (word count, payload words, XOR checksum) and assembles little-endian 32-bit words. Each word is written through a single-cycle write port. The core is held in reset until a valid image has landed.

Parameters:
XLEN, 32, width of wr_addr (byte address).
DEPTH_WORDS, 8192, instruction memory capacity in 32-bit words; the upper bound for the header count.
CNT_W, 14, width of the word counter; must satisfy 2^CNT_W > DEPTH_WORDS.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse that arms or re-arms the loader
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle
wr_en  out  1  instruction memory write strobe
wr_addr  out  XLEN  byte address of the write; always word-aligned
wr_data  out  32  write word
busy  out  1  high in HDR, PAYLOAD and CSUM
done  out  1  image loaded and checksum matched
error  out  1  oversize header or checksum mismatch
core_rst  out  1  reset request to the core; active-high

Behaviour:
- Reset (async): state=IDLE; in_ready, wr_en, busy, done and error are 0; wr_addr=0; wr_data=0; core_rst=1; lane, word and checksum counters are 0.
- A byte is accepted only when in_valid && in_ready. in_ready=1 only in HDR, PAYLOAD and CSUM. The loader never stalls internally in those states.
- Byte assembly: 2-bit lane counter; byte k of a word goes to bits [8k+7:8k] (little-endian). The lane counter wraps 3->0 on the 4th accepted byte, which completes a word.
- IDLE: waits for start. On start -> HDR; clear counters; done=0, error=0, core_rst=1.
- HDR: the first completed word is N.
  - N > DEPTH_WORDS -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> PAYLOAD.
- PAYLOAD: on each completed word:
  - Next cycle: wr_en=1 for exactly one cycle, wr_addr = word_idx*4 (word_idx 0..N-1, zero-extended to XLEN), wr_data = the word.
  - csum ^= word; word_idx++.
  - After word N-1 completes -> CSUM. The final write strobe overlaps the first CSUM cycle.
  - wr_en is 0 at all other times and in all other states.
- CSUM: on the completed word, compare with csum; equal -> DONE, else -> ERR. The XOR of zero words is 0.
- DONE: done=1, core_rst=0, in_ready=0. Held until start or rst.
- ERR: error=1, core_rst=1, in_ready=0. Held until start or rst.
- start in DONE or ERR behaves as in IDLE: core_rst returns to 1 the cycle after start. start in HDR, PAYLOAD or CSUM is ignored.
- Gaps: in_valid may drop at any point, including mid-word. The partial word and lane are retained indefinitely; there is no timeout.
- Bytes presented while in_ready=0 are not consumed.
- rst mid-load: immediate return to reset values. Memory already written is not cleared. done stays 0 until a full new image is loaded.
- Latency: wr_en is asserted 1 cycle after the accepting edge of the 4th byte. done/error is asserted 1 cycle after the last checksum byte is accepted.

Decomposition:
- Shared header or package imem_loader_defs:
  - state encodings IDLE=0, HDR=1, PAYLOAD=2, CSUM=3, DONE=4, ERR=5;
  - lane width 2;
  - the word byte-count constant 4.
- Sub-module byte_to_word:
  - inputs clk, rst, byte, accept, clear;
  - outputs word[31:0] and word_valid (single-cycle).
  - Owns the lane counter and shift register. The FSM, counters, checksum and write port stay in imem_loader.

Test Plan:
1. rst, start, stream 02 00 00 00 | 93 02 10 06 | 13 05 00 68 | checksum 80 07 10 6e -> wr_en pulses twice: (addr 0x0, 0x06100293) then (addr 0x4, 0x68000513); then done=1, core_rst=0, error=0.
2. start, header 00 00 00 00, checksum 00 00 00 00 -> no wr_en; done=1 one cycle after the last byte.
3. As scenario 1 but checksum 00 00 00 00 -> both writes occur; error=1, done=0, core_rst=1. Then start plus a correct image -> done=1.
4. Header N=8193 (01 20 00 00) with DEPTH_WORDS=8192 -> ERR after the 4th byte; in_ready=0; no wr_en.
5. Scenario 1 with in_valid dropped for 5 cycles after every byte, plus a start pulse mid-payload -> identical writes and result; start is ignored.
6. Assert rst after the 2nd payload byte, then start and a full scenario-1 image -> the first write is addr 0x0 with the correct word (no stale partial bytes); done=1.
